traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
- Receives the 2-bit highway and country lamp codes and the sensor X line that drive the intersection.
- Decodes each code into one-hot lamp drives and reconstructs the controller phase.
- Independently checks the sequence for safety, ordering, yellow/all-red timing and sensor consistency, raising sticky error flags and keeping a saturating error counter.
- Sits between the light controller and the board LEDs, and doubles as an on-chip checker.

Parameters:
- YEL_MIN, 4: minimum cycles a yellow phase (P1, P4) must last.
- AR_MIN, 2: minimum cycles the all-red phase (P2) must last.
- DW_W, 16: width of the dwell counter.

Ports:
- CLOCK_50 input 1: system clock; all logic on rising edge.
- clear input 1: asynchronous, active-high reset.
- hwy input 2: highway lamp code (00=G, 01=Y, 10=R, 11=illegal); synchronous to CLOCK_50.
- cntry input 2: country lamp code, same encoding.
- sensor_x input 1: country-road vehicle sensor.
- hwy_lamp output 3: one-hot {R,Y,G} highway drive.
- cntry_lamp output 3: one-hot {R,Y,G} country drive.
- phase output 3: reconstructed phase 0..4; 3'b111 = unknown.
- dwell output DW_W: cycles spent in the current phase, saturating.
- err_conflict output 1: sticky; both roads non-red.
- err_code output 1: sticky; a code of 11 was seen.
- err_seq output 1: sticky; illegal phase transition.
- err_timing output 1: sticky; yellow or all-red phase shorter than its minimum.
- err_sensor output 1: sticky; P0->P1 taken with sensor low.
- err_count output 8: number of error cycles, saturating at 255.

Behaviour:
- Reset (async, while clear=1):
  - lamps = 000, phase = 111, dwell = 0.
  - All err_* = 0, err_count = 0, sensor register = 0, FSM = SYNC.
- Phase map (hwy/cntry):
  - P0 = G/R, P1 = Y/R, P2 = R/R, P3 = R/G, P4 = R/Y.
  - Any other pair is unknown.
- Latency: all outputs are registered, one cycle after the inputs are sampled.
- Lamp decode:
  - 00 -> 001, 01 -> 010, 10 -> 100.
  - 11 -> 111 (all lamps on, as a visible fault).
- FSM SYNC:
  - Phase output = 111; dwell held at 0.
  - On the first cycle the pair is P0..P4, adopt that phase, dwell = 1, go to TRACK.
  - No err_seq, err_timing or err_sensor is raised in SYNC.
- FSM TRACK:
  - Legal moves: stay in the same phase, or P0->P1->P2->P3->P4->P0.
  - Same phase: dwell increments, saturating at all-ones.
  - Legal change: evaluate the leaving phase's dwell, then adopt the new phase with dwell = 1.
  - err_timing when leaving P1 or P4 with dwell < YEL_MIN, or leaving P2 with dwell < AR_MIN.
  - Change to a different legal phase that is not the successor: err_seq; adopt the new phase, dwell = 1, stay in TRACK. No timing check on that edge.
  - P0->P1 with registered sensor_x (previous cycle) = 0: err_sensor.
  - Unknown pair: go to SYNC, phase = 111. err_seq is not raised, but err_conflict and err_code still apply.
- Checks active in every state:
  - err_conflict when neither code is 10 and neither is 11.
  - err_code when either code is 11.
- Error flags are sticky until reset.
- err_count:
  - Increments by exactly 1 in any cycle where at least one error condition fires, whether new or repeated, regardless of how many fire.
  - Saturates at 255; no wrap.
- Simultaneous events:
  - 11/00 sets err_code only.
  - 00/01 sets err_conflict, then SYNC.
  - Both count as one error cycle.
- Reset mid-operation: immediate return to reset values; the next legal pair after release resynchronises.

Test Plan:
- Reset, then hold G/R for 5 cycles with sensor=1. Then Y/R 4, R/R 2, R/G 3, R/Y 4, back to G/R -> phase steps 0,1,2,3,4,0 one cycle late; all err_* = 0; err_count = 0; hwy_lamp = 001 during P0.
- Same sequence but Y/R held only 2 cycles -> err_timing = 1 on the cycle after P2 is sampled; err_count = 1; other flags 0.
- In TRACK at P0, apply G/G for 1 cycle, then R/R -> err_conflict = 1, phase = 111, then phase = 2 with no err_seq; err_count = 1.
- At P0, jump directly to R/G -> err_seq = 1, phase = 3, dwell = 1, err_count = 1.
- At P0 with sensor=0, move to Y/R -> err_sensor = 1. Repeat with sensor=1 after reset -> no error.
- Hold 11/10 for 300 cycles -> err_code = 1; hwy_lamp = 111; err_count saturates at 255. Assert clear mid-run -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Decodes the highway/country lamp codes into one-hot LED drives,
// reconstructs the controller phase (P0..P4) and checks the observed
// sequence for safety, ordering, yellow/all-red timing and sensor
// consistency. Every output is registered, so it reflects the inputs
// sampled on the most recent rising edge of CLOCK_50.

module traffic_light_monitor #(
  parameter int YEL_MIN = 4,   // minimum cycles in P1 / P4
  parameter int AR_MIN  = 2,   // minimum cycles in P2
  parameter int DW_W    = 16   // dwell counter width
) (
  input  logic            CLOCK_50,
  input  logic            clear,
  input  logic [1:0]      hwy,
  input  logic [1:0]      cntry,
  input  logic            sensor_x,
  output logic [2:0]      hwy_lamp,
  output logic [2:0]      cntry_lamp,
  output logic [2:0]      phase,
  output logic [DW_W-1:0] dwell,
  output logic            err_conflict,
  output logic            err_code,
  output logic            err_seq,
  output logic            err_timing,
  output logic            err_sensor,
  output logic [7:0]      err_count
);

  // Lamp code encoding shared by both roads.
  localparam logic [1:0] CODE_G = 2'b00;
  localparam logic [1:0] CODE_Y = 2'b01;
  localparam logic [1:0] CODE_R = 2'b10;
  localparam logic [1:0] CODE_X = 2'b11;

  // Phase encoding; PH_UNK marks "not locked to a known phase".
  localparam logic [2:0] PH_0   = 3'd0;
  localparam logic [2:0] PH_1   = 3'd1;
  localparam logic [2:0] PH_2   = 3'd2;
  localparam logic [2:0] PH_3   = 3'd3;
  localparam logic [2:0] PH_4   = 3'd4;
  localparam logic [2:0] PH_UNK = 3'b111;

  localparam logic [DW_W-1:0] DW_ONE   = DW_W'(1);
  localparam logic [DW_W-1:0] DW_MAX   = '1;
  localparam logic [DW_W-1:0] YEL_MINW = DW_W'(YEL_MIN);
  localparam logic [DW_W-1:0] AR_MINW  = DW_W'(AR_MIN);

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // One-hot {R,Y,G} drive; the illegal code lights every lamp so the
  // fault is visible on the board.
  function automatic logic [2:0] lamp_decode(input logic [1:0] code);
    logic [2:0] lamp;
    lamp = 3'b111;
    case (code)
      CODE_G:  lamp = 3'b001;
      CODE_Y:  lamp = 3'b010;
      CODE_R:  lamp = 3'b100;
      default: lamp = 3'b111;
    endcase
    return lamp;
  endfunction

  // Registered state
  state_t          state_q, state_d;
  logic [2:0]      phase_q, phase_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [2:0]      hwy_lamp_q, cntry_lamp_q;
  logic            sensor_q;
  logic            conflict_q, code_q, seq_q, timing_q, sensor_err_q;
  logic [7:0]      count_q, count_d;

  // Combinational decode / check results for the current sample
  logic            pair_known;
  logic [2:0]      pair_phase;
  logic [2:0]      succ_phase;
  logic            conflict_c, code_c, seq_c, timing_c, sensor_c;
  logic            any_err_c;

  // Map the lamp-code pair onto a controller phase.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    pair_known = 1'b1;
    pair_phase = PH_UNK;
    case ({hwy, cntry})
      {CODE_G, CODE_R}: pair_phase = PH_0;
      {CODE_Y, CODE_R}: pair_phase = PH_1;
      {CODE_R, CODE_R}: pair_phase = PH_2;
      {CODE_R, CODE_G}: pair_phase = PH_3;
      {CODE_R, CODE_Y}: pair_phase = PH_4;
      default:          pair_known = 1'b0;
    endcase
  end

  // Safety checks that apply regardless of FSM state.
  always_comb begin
    code_c     = (hwy == CODE_X) || (cntry == CODE_X);
    conflict_c = (hwy != CODE_R) && (cntry != CODE_R) && !code_c;
  end

  // Phase tracker: next state, phase, dwell and the ordering checks.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    dwell_d    = dwell_q;
    seq_c      = 1'b0;
    timing_c   = 1'b0;
    sensor_c   = 1'b0;
    succ_phase = (phase_q == PH_4) ? PH_0 : phase_q + 3'd1;

    case (state_q)
      ST_SYNC: begin
        phase_d = PH_UNK;
        dwell_d = '0;
        if (pair_known) begin
          phase_d = pair_phase;
          dwell_d = DW_ONE;
          state_d = ST_TRACK;
        end
      end

      ST_TRACK: begin
        if (!pair_known) begin
          state_d = ST_SYNC;
          phase_d = PH_UNK;
          dwell_d = '0;
        end else if (pair_phase == phase_q) begin
          dwell_d = (dwell_q == DW_MAX) ? dwell_q : dwell_q + DW_ONE;
        end else if (pair_phase == succ_phase) begin
          // The dwell of the phase being left is judged here, before it
          // is overwritten by the new phase's first cycle.
          timing_c = (((phase_q == PH_1) || (phase_q == PH_4)) && (dwell_q < YEL_MINW))
                  || ((phase_q == PH_2) && (dwell_q < AR_MINW));
          sensor_c = (phase_q == PH_0) && !sensor_q;
          phase_d  = pair_phase;
          dwell_d  = DW_ONE;
        end else begin
          // Out-of-order jump: flag it but keep following the controller.
          seq_c   = 1'b1;
          phase_d = pair_phase;
          dwell_d = DW_ONE;
        end
      end

      default: begin
        state_d = ST_SYNC;
        phase_d = PH_UNK;
        dwell_d = '0;
      end
    endcase
  end

  // One count per error cycle, however many conditions fire together.
  always_comb begin
    any_err_c = conflict_c | code_c | seq_c | timing_c | sensor_c;
    count_d   = count_q;
    if (any_err_c && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // State, decode and sticky error registers.
  always_ff @(posedge CLOCK_50 or posedge clear) begin
    if (clear) begin
      state_q      <= ST_SYNC;
      phase_q      <= PH_UNK;
      dwell_q      <= '0;
      hwy_lamp_q   <= 3'b000;
      cntry_lamp_q <= 3'b000;
      sensor_q     <= 1'b0;
      conflict_q   <= 1'b0;
      code_q       <= 1'b0;
      seq_q        <= 1'b0;
      timing_q     <= 1'b0;
      sensor_err_q <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples
      // the pre-edge values, independent of statement order.
      state_q      <= state_d;
      phase_q      <= phase_d;
      dwell_q      <= dwell_d;
      hwy_lamp_q   <= lamp_decode(hwy);
      cntry_lamp_q <= lamp_decode(cntry);
      sensor_q     <= sensor_x;
      conflict_q   <= conflict_q   | conflict_c;
      code_q       <= code_q       | code_c;
      seq_q        <= seq_q        | seq_c;
      timing_q     <= timing_q     | timing_c;
      sensor_err_q <= sensor_err_q | sensor_c;
      count_q      <= count_d;
    end
  end

  assign hwy_lamp     = hwy_lamp_q;
  assign cntry_lamp   = cntry_lamp_q;
  assign phase        = phase_q;
  assign dwell        = dwell_q;
  assign err_conflict = conflict_q;
  assign err_code     = code_q;
  assign err_seq      = seq_q;
  assign err_timing   = timing_q;
  assign err_sensor   = sensor_err_q;
  assign err_count    = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor. Inputs change 1 time unit
// after a rising edge; outputs are checked at the same point, so each
// check sees the result of the edge that just sampled the step's inputs.

module tb_traffic_light_monitor;

  localparam int DW_W = 16;

  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic            clk = 1'b0;
  logic            clear;
  logic [1:0]      hwy, cntry;
  logic            sensor_x;
  logic [2:0]      hwy_lamp, cntry_lamp, phase;
  logic [DW_W-1:0] dwell;
  logic            err_conflict, err_code, err_seq, err_timing, err_sensor;
  logic [7:0]      err_count;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  traffic_light_monitor #(.YEL_MIN(4), .AR_MIN(2), .DW_W(DW_W)) dut (
    .CLOCK_50    (clk),
    .clear       (clear),
    .hwy         (hwy),
    .cntry       (cntry),
    .sensor_x    (sensor_x),
    .hwy_lamp    (hwy_lamp),
    .cntry_lamp  (cntry_lamp),
    .phase       (phase),
    .dwell       (dwell),
    .err_conflict(err_conflict),
    .err_code    (err_code),
    .err_seq     (err_seq),
    .err_timing  (err_timing),
    .err_sensor  (err_sensor),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Flags packed {conflict, code, seq, timing, sensor}.
  task automatic check_errs(input string tag, input logic [4:0] flags, input logic [7:0] cnt);
    check({tag, ".flags"}, {27'd0, err_conflict, err_code, err_seq, err_timing, err_sensor},
          {27'd0, flags});
    check({tag, ".count"}, {24'd0, err_count}, {24'd0, cnt});
  endtask

  task automatic check_ph(input string tag, input logic [2:0] ph, input logic [DW_W-1:0] dw);
    check({tag, ".phase"}, {29'd0, phase}, {29'd0, ph});
    check({tag, ".dwell"}, {16'd0, dwell}, {16'd0, dw});
  endtask

  task automatic step(input logic [1:0] h, input logic [1:0] c, input logic s, input int n);
    repeat (n) begin
      hwy      = h;
      cntry    = c;
      sensor_x = s;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    clear = 1'b1;
    #2;
    clear = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".hlamp"}, {29'd0, hwy_lamp},   32'd0);
    check({tag, ".clamp"}, {29'd0, cntry_lamp}, 32'd0);
    check_ph(tag, 3'b111, '0);
    check_errs(tag, 5'b00000, 8'd0);
  endtask

  initial begin
    clear    = 1'b1;
    hwy      = G;
    cntry    = R;
    sensor_x = 1'b0;

    // Reset state while clear is held across edges.
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    clear = 1'b0;

    // 1: full legal cycle.
    step(G, R, 1'b1, 1);
    check_ph("c1.p0first", 3'd0, 16'd1);
    check("c1.hlamp", {29'd0, hwy_lamp},   32'b001);
    check("c1.clamp", {29'd0, cntry_lamp}, 32'b100);
    step(G, R, 1'b1, 4);
    check_ph("c1.p0", 3'd0, 16'd5);
    step(Y, R, 1'b1, 1);
    check_ph("c1.p1first", 3'd1, 16'd1);
    check("c1.p1hlamp", {29'd0, hwy_lamp}, 32'b010);
    step(Y, R, 1'b1, 3);
    check_ph("c1.p1", 3'd1, 16'd4);
    step(R, R, 1'b1, 2);
    check_ph("c1.p2", 3'd2, 16'd2);
    step(R, G, 1'b1, 3);
    check_ph("c1.p3", 3'd3, 16'd3);
    check("c1.p3clamp", {29'd0, cntry_lamp}, 32'b001);
    step(R, Y, 1'b1, 4);
    check_ph("c1.p4", 3'd4, 16'd4);
    step(G, R, 1'b1, 1);
    check_ph("c1.back", 3'd0, 16'd1);
    check_errs("c1", 5'b00000, 8'd0);

    // 2: short yellow.
    pulse_reset();
    step(G, R, 1'b1, 5);
    step(Y, R, 1'b1, 2);
    check_errs("c2.pre", 5'b00000, 8'd0);
    step(R, R, 1'b1, 1);
    check_errs("c2.short", 5'b00010, 8'd1);
    check_ph("c2.p2", 3'd2, 16'd1);
    step(R, R, 1'b1, 1);
    step(R, G, 1'b1, 3);
    step(R, Y, 1'b1, 4);
    step(G, R, 1'b1, 1);
    check_errs("c2.end", 5'b00010, 8'd1);

    // 3: conflict drops to SYNC, resync on R/R without err_seq.
    pulse_reset();
    step(G, R, 1'b1, 2);
    step(G, G, 1'b1, 1);
    check_errs("c3.gg", 5'b10000, 8'd1);
    check_ph("c3.gg", 3'b111, '0);
    step(R, R, 1'b1, 1);
    check_ph("c3.rr", 3'd2, 16'd1);
    check_errs("c3.rr", 5'b10000, 8'd1);

    // 4: out-of-order jump P0 -> P3.
    pulse_reset();
    step(G, R, 1'b1, 2);
    step(R, G, 1'b1, 1);
    check_ph("c4.jump", 3'd3, 16'd1);
    check_errs("c4.jump", 5'b00100, 8'd1);

    // 5a: P0 -> P1 with sensor low.
    pulse_reset();
    step(G, R, 1'b0, 3);
    step(Y, R, 1'b0, 1);
    check_errs("c5a", 5'b00001, 8'd1);
    // 5b: sensor high throughout.
    pulse_reset();
    step(G, R, 1'b1, 3);
    step(Y, R, 1'b1, 1);
    check_errs("c5b", 5'b00000, 8'd0);
    // 5c: sensor rises only on the transition cycle -> still an error,
    // because the check uses the previous cycle's sensor sample.
    pulse_reset();
    step(G, R, 1'b0, 3);
    step(Y, R, 1'b1, 1);
    check_errs("c5c", 5'b00001, 8'd1);

    // 6: simultaneous events, one error cycle each.
    pulse_reset();
    step(X, G, 1'b1, 1);
    check_errs("c6.xg", 5'b01000, 8'd1);
    check("c6.xg.hlamp", {29'd0, hwy_lamp}, 32'b111);
    step(G, Y, 1'b1, 1);
    check_errs("c6.gy", 5'b11000, 8'd2);
    check_ph("c6.gy", 3'b111, '0);

    // 7: long illegal code, counter saturation, async clear mid-run.
    pulse_reset();
    step(X, R, 1'b1, 1);
    check_errs("c7.first", 5'b01000, 8'd1);
    check("c7.hlamp", {29'd0, hwy_lamp},   32'b111);
    check("c7.clamp", {29'd0, cntry_lamp}, 32'b100);
    check_ph("c7.first", 3'b111, '0);
    step(X, R, 1'b1, 253);
    check("c7.254", {24'd0, err_count}, 32'd254);
    step(X, R, 1'b1, 1);
    check("c7.255", {24'd0, err_count}, 32'd255);
    step(X, R, 1'b1, 45);
    check_errs("c7.sat", 5'b01000, 8'd255);
    clear = 1'b1;
    #1;
    check_reset_vals("c7.clr");
    #1;
    clear = 1'b0;
    step(G, R, 1'b1, 1);
    check_ph("c7.resync", 3'd0, 16'd1);
    check_errs("c7.resync", 5'b00000, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
